axi_ax_snoop_stream_buf: RTL
============================

// Module: axi_ax_snoop_stream_buf
// PURPOSE
//  Buffered successor to the AR/AW snooper. Passes one AXI4 AR or AW channel through combinationally.
//  Copies every accepted Ax handshake into a DEPTH-entry FIFO and streams it as 1 or 2 beats to the
//  stream arbiter (valid/ready/in_progress/last/data). The AXI side no longer stalls on stream
//  ready; it stalls only on FIFO full, or never in drop mode.
// PARAMETERS
//  DATA_WIDTH 128 stream beat width; must be >= STREAM_TYPE_WIDTH+ID_WIDTH+BURST_LEN+ADDR_WIDTH(+TS_WIDTH)
//  ADDR_WIDTH 64 / ID_WIDTH 32 / BURST_LEN 8 / LOCK_WIDTH 2 / USER_WIDTH 64: AXI field widths
//  STREAM_TYPE 3'b0 / STREAM_TYPE_WIDTH 3: record type tag placed in data MSBs of every beat
//  DEPTH 4: FIFO entries, power of two, >= 2
//  EXT_MODE 0: 0 = 1-beat record; 1 = 2-beat record (adds attribute beat)
//  DROP_ON_FULL 0: 0 = back-pressure AXI when full; 1 = never stall AXI, drop and count
//  DROP_CNT_WIDTH 16: drop counter width
//  TS_WIDTH 32: timestamp width (used only with AX_SNOOP_TS_EN)
// PORTS
//  clk              in  1   clock
//  resetn           in  1   asynchronous active-low reset
//  ready            in  1   arbiter accepts current beat
//  valid            out 1   beat on data is valid
//  in_progress      out 1   multi-beat record open; arbiter must not switch source
//  last             out 1   current beat is the final beat of the record
//  data             out DATA_WIDTH  beat payload
//  drop_count       out DROP_CNT_WIDTH  saturating count of records dropped (0 if DROP_ON_FULL=0)
//  AXIS_ax*         in/out  AXI slave side: id,addr,len,size,burst,lock,cache,prot,region,qos,user,valid / ready
//  AXIM_ax*         out/in  AXI master side: same fields / ready
// BEHAVIOUR
//  - Payload fields AXIM_ax* = AXIS_ax* combinationally, always.
//  - Handshake: DROP_ON_FULL=0: AXIM_axvalid = AXIS_axvalid & (~resetn | ~full);
//    AXIS_axready = AXIM_axready & (~resetn | ~full). DROP_ON_FULL=1: pure wires.
//  - push = resetn & AXIS_axvalid & AXIM_axready & ~full. full/empty are registered from pointers.
//    Push at full with simultaneous pop is refused, never accepted.
//  - Drop: DROP_ON_FULL=1 and handshake while full -> drop_count += 1, saturates at all-ones.
//  - Beat0 data = {STREAM_TYPE, id, len, zero pad, addr}. Beat1 (EXT_MODE=1) = {STREAM_TYPE, size, burst,
//    lock, cache, prot, region, qos, zero pad, user}. Beat1 truncates user MSBs if DATA_WIDTH is short.
//  - Latency: record visible on valid the cycle after its AXI handshake (registered output, no comb path AXI->valid).
//  - Output FSM: BEAT0 -> (valid&ready, EXT_MODE=1) -> BEAT1 -> (valid&ready) -> BEAT0 with FIFO pop.
//    EXT_MODE=0: pop on valid&ready in BEAT0. valid = ~empty. last = valid & (EXT_MODE=0 | state==BEAT1).
//    in_progress = (state==BEAT1). data holds stable while valid&~ready.
//  - Ordering strictly FIFO; no reordering or merging.
//  - Reset (any time, async): pointers, FSM=BEAT0, drop_count=0; valid/last/in_progress=0 and data=0.
//    Records in flight are discarded. During reset the AXI channel is transparent and nothing is captured.
// CONFIGURATION
//  AX_SNOOP_TS_EN defined: free-running TS_WIDTH counter (reset 0, wraps).
//    Its value at the push cycle is stored per entry and placed in beat0 bits [ADDR_WIDTH+TS_WIDTH-1:ADDR_WIDTH].
//  Undefined: no counter, those bits are zero padding; record layout otherwise identical.
// STRUCTURE
//  Shared package ax_snoop_pkg: beat-state enum (BEAT0/BEAT1), stream-type codes (AR/AW),
//    width-check function asserting DATA_WIDTH fit at elaboration.
//  Sub-module ax_snoop_fifo: generic sync FIFO (WIDTH, DEPTH; push/pop/full/empty, async resetn).
//  Top holds handshake masking, packing, output FSM, drop counter, optional timestamp.
// TESTING
//  1. EXT_MODE=0, ready=1, one AR id=5 addr=0x1000 len=3 -> next cycle valid=last=1, data fields match, in_progress=0.
//  2. DROP_ON_FULL=0, DEPTH=4, ready=0, 5 back-to-back Ax -> 4 accepted, AXIS_axready=0 on 5th.
//     Raising ready drains 4 in order, then the 5th is accepted.
//  3. DROP_ON_FULL=1, ready=0, 6 Ax -> all 6 see AXIS_axready=1; drop_count=2; 4 records stream out.
//     DROP_CNT_WIDTH=2 with 5 drops -> saturates at 3.
//  4. EXT_MODE=1, ready toggling 1/0 -> beat0 last=0 in_progress=0, beat1 last=1 in_progress=1.
//     data stable while stalled.
//  5. Reset asserted mid-BEAT1 with 2 queued -> outputs 0 immediately; after release FIFO empty, FSM=BEAT0.
//     AXI passthrough works throughout.
//  6. AX_SNOOP_TS_EN: pushes at counter 10 and 13 -> beat0 TS fields 10 and 13. Without macro -> fields 0.

Source files
------------

// File: rtl/ax_snoop_pkg.sv
// Shared types, stream-type codes and width helpers for the Ax snoop stream buffer.
package ax_snoop_pkg;

    // Output beat sequencer state
    typedef enum logic {
        BEAT0 = 1'b0,
        BEAT1 = 1'b1
    } beat_state_e;

    // Record type tags carried in the beat MSBs
    localparam logic [2:0] STREAM_TYPE_AR = 3'd0;
    localparam logic [2:0] STREAM_TYPE_AW = 3'd1;

    // Fixed AXI4 Ax attribute widths
    localparam int unsigned AX_SIZE_W   = 3;
    localparam int unsigned AX_BURST_W  = 2;
    localparam int unsigned AX_CACHE_W  = 4;
    localparam int unsigned AX_PROT_W   = 3;
    localparam int unsigned AX_REGION_W = 4;
    localparam int unsigned AX_QOS_W    = 4;

    // Width of the packed attribute field in the second beat
    function automatic int unsigned attr_width(input int unsigned lock_w);
        return AX_SIZE_W + AX_BURST_W + lock_w + AX_CACHE_W + AX_PROT_W + AX_REGION_W + AX_QOS_W;
    endfunction

    // True when both beat layouts fit in the stream data width
    function automatic bit width_ok(input int unsigned data_w, input int unsigned type_w,
                                    input int unsigned id_w, input int unsigned len_w,
                                    input int unsigned addr_w, input int unsigned ts_w,
                                    input int unsigned lock_w);
        return (data_w >= type_w + id_w + len_w + addr_w + ts_w) &&
               (data_w >  type_w + attr_width(lock_w));
    endfunction

endpackage

// File: rtl/axi_ax_snoop_stream_buf_if.sv
// One AXI4 AR or AW channel; master drives payload/valid, slave drives ready.
interface axi_ax_snoop_stream_buf_if
    import ax_snoop_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 32,
    parameter int unsigned BURST_LEN  = 8,
    parameter int unsigned LOCK_WIDTH = 2,
    parameter int unsigned USER_WIDTH = 64
);
    logic [ID_WIDTH-1:0]    id;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [BURST_LEN-1:0]   len;
    logic [AX_SIZE_W-1:0]   size;
    logic [AX_BURST_W-1:0]  burst;
    logic [LOCK_WIDTH-1:0]  lock;
    logic [AX_CACHE_W-1:0]  cache;
    logic [AX_PROT_W-1:0]   prot;
    logic [AX_REGION_W-1:0] region;
    logic [AX_QOS_W-1:0]    qos;
    logic [USER_WIDTH-1:0]  user;
    logic                   valid;
    logic                   ready;

    modport master (
        output id, addr, len, size, burst, lock, cache, prot, region, qos, user, valid,
        input  ready
    );

    modport slave (
        input  id, addr, len, size, burst, lock, cache, prot, region, qos, user, valid,
        output ready
    );
endinterface

// File: rtl/ax_snoop_fifo.sv
// Generic synchronous FIFO with registered full/empty flags; a push while full is refused.
module ax_snoop_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_err
        $error("ax_snoop_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [CNT_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] wr_ptr_d, rd_ptr_d;
    logic             full_q, empty_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign do_push = push & ~full_q;
    assign do_pop  = pop & ~empty_q;

    // Next pointer values
    always_comb begin
        wr_ptr_d = wr_ptr_q + CNT_W'(do_push);
        rd_ptr_d = rd_ptr_q + CNT_W'(do_pop);
    end

    // Pointers and flags, flags derived from the next pointers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= (wr_ptr_d[PTR_W] != rd_ptr_d[PTR_W]) &&
                        (wr_ptr_d[PTR_W-1:0] == rd_ptr_d[PTR_W-1:0]);
            empty_q  <= (wr_ptr_d == rd_ptr_d);
        end
    end

    // Storage, cleared on reset so the read port never shows X
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/axi_ax_snoop_stream_buf.sv
// Buffered AXI AR/AW snooper: transparent channel pass-through, each accepted
// handshake is queued and streamed out as a 1- or 2-beat record.
// Optional feature macro: AX_SNOOP_TS_EN (per-record push timestamp in beat 0).
module axi_ax_snoop_stream_buf
    import ax_snoop_pkg::*;
#(
    parameter int unsigned DATA_WIDTH        = 128,
    parameter int unsigned ADDR_WIDTH        = 64,
    parameter int unsigned ID_WIDTH          = 32,
    parameter int unsigned BURST_LEN         = 8,
    parameter int unsigned LOCK_WIDTH        = 2,
    parameter int unsigned USER_WIDTH        = 64,
    parameter int unsigned STREAM_TYPE_WIDTH = 3,
    parameter logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE = STREAM_TYPE_WIDTH'(STREAM_TYPE_AR),
    parameter int unsigned DEPTH             = 4,
    parameter int unsigned EXT_MODE          = 0,
    parameter int unsigned DROP_ON_FULL      = 0,
    parameter int unsigned DROP_CNT_WIDTH    = 16,
    parameter int unsigned TS_WIDTH          = 32
) (
    input  logic                      clk,
    input  logic                      resetn,
    axi_ax_snoop_stream_buf_if.slave  axis,
    axi_ax_snoop_stream_buf_if.master axim,
    input  logic                      ready,
    output logic                      valid,
    output logic                      in_progress,
    output logic                      last,
    output logic [DATA_WIDTH-1:0]     data,
    output logic [DROP_CNT_WIDTH-1:0] drop_count
);
`ifdef AX_SNOOP_TS_EN
    localparam bit TS_USED = 1'b1;
`else
    localparam bit TS_USED = 1'b0;
`endif
    localparam int unsigned TS_BITS    = TS_USED ? TS_WIDTH : 0;
    localparam int unsigned STW        = STREAM_TYPE_WIDTH;
    localparam int unsigned ATTR_W     = attr_width(LOCK_WIDTH);
    localparam int unsigned ENTRY_W    = ID_WIDTH + ADDR_WIDTH + BURST_LEN + ATTR_W + USER_WIDTH + TS_BITS;
    localparam int unsigned USER_ROOM  = DATA_WIDTH - STW - ATTR_W;
    localparam int unsigned USER_KEEP  = (USER_WIDTH < USER_ROOM) ? USER_WIDTH : USER_ROOM;

    if (!width_ok(DATA_WIDTH, STW, ID_WIDTH, BURST_LEN, ADDR_WIDTH, TS_BITS, LOCK_WIDTH)) begin : g_width_err
        $error("axi_ax_snoop_stream_buf: DATA_WIDTH too small for the record layout");
    end

    logic                      full, empty, push, pop, drop_hit;
    logic [ENTRY_W-1:0]        entry_in, entry_out;
    logic [ID_WIDTH-1:0]       e_id;
    logic [ADDR_WIDTH-1:0]     e_addr;
    logic [BURST_LEN-1:0]      e_len;
    logic [ATTR_W-1:0]         e_attr;
    logic [USER_WIDTH-1:0]     e_user;
    logic [DATA_WIDTH-1:0]     beat0, beat1;
    logic [DROP_CNT_WIDTH-1:0] drop_q;
    beat_state_e               state_q, state_d;

    // Payload always passes straight through
    assign axim.id     = axis.id;
    assign axim.addr   = axis.addr;
    assign axim.len    = axis.len;
    assign axim.size   = axis.size;
    assign axim.burst  = axis.burst;
    assign axim.lock   = axis.lock;
    assign axim.cache  = axis.cache;
    assign axim.prot   = axis.prot;
    assign axim.region = axis.region;
    assign axim.qos    = axis.qos;
    assign axim.user   = axis.user;

    // Handshake: stall on full unless dropping; transparent while in reset
    if (DROP_ON_FULL != 0) begin : g_hs_drop
        assign axim.valid = axis.valid;
        assign axis.ready = axim.ready;
    end else begin : g_hs_stall
        assign axim.valid = axis.valid & (~resetn | ~full);
        assign axis.ready = axim.ready & (~resetn | ~full);
    end

    assign push     = resetn & axis.valid & axim.ready & ~full;
    assign drop_hit = (DROP_ON_FULL != 0) & resetn & axis.valid & axim.ready & full;

`ifdef AX_SNOOP_TS_EN
    logic [TS_WIDTH-1:0] ts_q;
    logic [TS_WIDTH-1:0] e_ts;

    // Free-running timestamp
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) ts_q <= '0;
        else         ts_q <= ts_q + TS_WIDTH'(1);
    end

    assign entry_in = {ts_q, axis.id, axis.addr, axis.len, axis.size, axis.burst, axis.lock,
                       axis.cache, axis.prot, axis.region, axis.qos, axis.user};
    assign {e_ts, e_id, e_addr, e_len, e_attr, e_user} = entry_out;
`else
    assign entry_in = {axis.id, axis.addr, axis.len, axis.size, axis.burst, axis.lock,
                       axis.cache, axis.prot, axis.region, axis.qos, axis.user};
    assign {e_id, e_addr, e_len, e_attr, e_user} = entry_out;
`endif

    ax_snoop_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .din    (entry_in),
        .dout   (entry_out),
        .full   (full),
        .empty  (empty)
    );

    // Beat formatting from the FIFO head
    always_comb begin
        beat0 = '0;
        beat0[ADDR_WIDTH-1:0]              = e_addr;
`ifdef AX_SNOOP_TS_EN
        beat0[ADDR_WIDTH +: TS_WIDTH]      = e_ts;
`endif
        beat0[DATA_WIDTH-1 -: STW]         = STREAM_TYPE;
        beat0[DATA_WIDTH-STW-1 -: ID_WIDTH] = e_id;
        beat0[DATA_WIDTH-STW-ID_WIDTH-1 -: BURST_LEN] = e_len;

        beat1 = '0;
        beat1[USER_KEEP-1:0]               = e_user[USER_KEEP-1:0];
        beat1[DATA_WIDTH-1 -: STW]         = STREAM_TYPE;
        beat1[DATA_WIDTH-STW-1 -: ATTR_W]  = e_attr;
    end

    // Beat sequencer state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= BEAT0;
        else         state_q <= state_d;
    end

    // Beat sequencing, FIFO pop and stream outputs
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        valid       = ~empty;
        in_progress = (state_q == BEAT1);
        last        = 1'b0;
        data        = '0;
        case (state_q)
            BEAT0: begin
                if (~empty & ready) begin
                    if (EXT_MODE != 0) state_d = BEAT1;
                    else               pop     = 1'b1;
                end
                last = ~empty & (EXT_MODE == 0);
                if (~empty) data = beat0;
            end
            BEAT1: begin
                if (~empty & ready) begin
                    state_d = BEAT0;
                    pop     = 1'b1;
                end
                last = ~empty;
                if (~empty) data = beat1;
            end
            default: state_d = BEAT0;
        endcase
    end

    // Saturating drop counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                        drop_q <= '0;
        else if (drop_hit && (drop_q != '1)) drop_q <= drop_q + DROP_CNT_WIDTH'(1);
    end

    assign drop_count = drop_q;

endmodule
